vram_wr_buffer: RTL

Bus-side front end for VRAM port A: accepts CPU/DMA 8/16/32-bit accesses, applies GBA VRAM store rules (byte stores duplicated across the halfword), and posts writes through a small FIFO. It drains one write per cycle into the 16K x 32 VRAM port as word address, data and byte enables. Reads are serialised behind all posted writes, so read-after-write is always coherent.

---
 rtl/vram_wr_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vram_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vram_wr_buffer
// Description : Bus front end for VRAM port A. Posted-write FIFO with GBA
//               lane formatting; reads serialised behind all queued writes.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_wr_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [1:0]  bus_size,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic [13:0] vram_addr,
  output logic [31:0] vram_data,
  output logic [3:0]  vram_be,
  output logic        vram_we,
  input  logic [31:0] vram_q,
  output logic        idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 14 + 4 + 32;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  logic [EW-1:0] fifo_q [DEPTH];
  logic [EW-1:0] fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic [13:0]   vram_addr_q, vram_addr_d;
  logic [31:0]   vram_data_q, vram_data_d;
  logic [3:0]    vram_be_q, vram_be_d;
  logic          vram_we_q, vram_we_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [15:0] half_val;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic        fifo_empty, fifo_full, rd_idle;
  logic        wr_ready, rd_ready, push, pop, rd_accept;
  logic        unused_addr0;

  assign unused_addr0 = bus_addr[0];

  // Byte stores replicate the byte across the halfword before lane placement.
  always_comb begin
    half_val = (bus_size == 2'd0) ? {bus_wdata[7:0], bus_wdata[7:0]} : bus_wdata[15:0];
    fmt_be   = 4'hF;
    fmt_data = bus_wdata;
    if (!bus_size[1]) begin
      if (bus_addr[1]) begin
        fmt_be   = 4'b1100;
        fmt_data = {half_val, 16'h0000};
      end else begin
        fmt_be   = 4'b0011;
        fmt_data = {16'h0000, half_val};
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign rd_idle    = (rd_state_q == RD_IDLE);
  assign wr_ready   = !fifo_full && rd_idle;
  assign rd_ready   = fifo_empty && !vram_we_q && rd_idle;
  assign bus_ready  = bus_we ? wr_ready : (bus_req && rd_ready);
  assign push       = bus_req && bus_we && wr_ready;
  assign rd_accept  = bus_req && !bus_we && rd_ready;
  assign pop        = !fifo_empty;

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    vram_be_d   = vram_be_q;
    vram_we_d   = 1'b0;
    rd_state_d  = rd_state_q;
    rdata_d     = rdata_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {bus_addr[15:2], fmt_be, fmt_data};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    // A read is only accepted with the FIFO empty, so it never races a pop.
    if (pop) begin
      {vram_addr_d, vram_be_d, vram_data_d} = fifo_q[rd_ptr_q];
      vram_we_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end else if (rd_accept) begin
      vram_addr_d = bus_addr[15:2];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (rd_state_q)
      RD_IDLE: if (rd_accept) rd_state_d = RD_ADDR;
      RD_ADDR: begin
        rdata_d    = vram_q;
        rd_state_d = RD_RESP;
      end
      RD_RESP: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      vram_be_q   <= '0;
      vram_we_q   <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      vram_be_q   <= vram_be_d;
      vram_we_q   <= vram_we_d;
      rd_state_q  <= rd_state_d;
      rdata_q     <= rdata_d;
    end
  end

  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign vram_be    = vram_be_q;
  assign vram_we    = vram_we_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = (rd_state_q == RD_RESP);
  assign idle       = fifo_empty && !vram_we_q && rd_idle;

endmodule
`default_nettype wire
